// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges X (ALU) and Y (mul) results onto the single
// register-file write port, buffering losing Y results in a small FIFO.
module writeback_arbiter #(
    parameter int DEPTH        = 8,
    parameter int STALL_MARGIN = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [4:0]               x_wb_regdest,
    input  logic                     x_wb_writereg,
    input  logic [31:0]              x_wb_wbvalue,
    input  logic [4:0]               y_wb_regdest,
    input  logic                     y_wb_writereg,
    input  logic [31:0]              y_wb_wbvalue,
    output logic [4:0]               wb_rf_regdest,
    output logic                     wb_rf_writereg,
    output logic [31:0]              wb_rf_wbvalue,
    output logic                     wb_is_stall,
    output logic [$clog2(DEPTH):0]   wb_fifo_count,
    output logic                     wb_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] THRESH = CW'(DEPTH - STALL_MARGIN);
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);

    typedef logic [AW-1:0] ptr_t;

    logic [4:0]       q_rd  [DEPTH];
    logic [31:0]      q_val [DEPTH];
    logic [DEPTH-1:0] q_vld;
    logic [DEPTH-1:0] squash;

    ptr_t          head;
    ptr_t          tail;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    logic x_ok;
    logic y_ok;
    logic y_waw;
    logic empty;
    logic pop;
    logic bypass;
    logic need_push;
    logic room;
    logic push;
    logic drop_full;

    logic        nxt_we;
    logic [4:0]  nxt_rd;
    logic [31:0] nxt_val;

    always_comb begin
        x_ok      = x_wb_writereg && (x_wb_regdest != 5'd0);
        y_ok      = y_wb_writereg && (y_wb_regdest != 5'd0);
        y_waw     = x_ok && y_ok && (y_wb_regdest == x_wb_regdest);
        empty     = (count == '0);
        pop       = !x_ok && !empty;
        bypass    = !x_ok && empty && y_ok;
        need_push = y_ok && !bypass && !y_waw;
        // A same-cycle pop frees the head slot before the push lands
        room      = (count != FULL) || pop;
        push      = need_push && room;
        drop_full = need_push && !room;
        count_next = count + CW'(push) - CW'(pop);

        for (int i = 0; i < DEPTH; i++) begin
            squash[i] = x_ok && (q_rd[i] == x_wb_regdest);
        end

        nxt_we  = 1'b0;
        nxt_rd  = 5'd0;
        nxt_val = 32'd0;
        unique case (1'b1)
            x_ok: begin
                nxt_we  = 1'b1;
                nxt_rd  = x_wb_regdest;
                nxt_val = x_wb_wbvalue;
            end
            pop: begin
                nxt_we  = q_vld[head];
                nxt_rd  = q_rd[head];
                nxt_val = q_val[head];
            end
            bypass: begin
                nxt_we  = 1'b1;
                nxt_rd  = y_wb_regdest;
                nxt_val = y_wb_wbvalue;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            q_vld          <= '0;
            wb_rf_regdest  <= '0;
            wb_rf_writereg <= 1'b0;
            wb_rf_wbvalue  <= '0;
            wb_is_stall    <= 1'b0;
            wb_overflow    <= 1'b0;
        end else begin
            count <= count_next;
            q_vld <= q_vld & ~squash;
            if (pop) begin
                head        <= head + ptr_t'(1);
                q_vld[head] <= 1'b0;
            end
            if (push) begin
                tail        <= tail + ptr_t'(1);
                q_vld[tail] <= 1'b1;
            end
            wb_rf_writereg <= nxt_we;
            wb_rf_regdest  <= nxt_rd;
            wb_rf_wbvalue  <= nxt_val;
            wb_is_stall    <= (count_next >= THRESH);
            wb_overflow    <= wb_overflow | drop_full;
        end
    end

    // Payload storage needs no reset; the valid bits gate every use
    always_ff @(posedge clock) begin
        if (push) begin
            q_rd[tail]  <= y_wb_regdest;
            q_val[tail] <= y_wb_wbvalue;
        end
    end

    assign wb_fifo_count = count;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: per-cycle expectations are queued
// as stimulus is driven and checked one cycle later.
module tb_writeback_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  x_wb_regdest;
    logic        x_wb_writereg;
    logic [31:0] x_wb_wbvalue;
    logic [4:0]  y_wb_regdest;
    logic        y_wb_writereg;
    logic [31:0] y_wb_wbvalue;
    logic [4:0]  wb_rf_regdest;
    logic        wb_rf_writereg;
    logic [31:0] wb_rf_wbvalue;
    logic        wb_is_stall;
    logic [3:0]  wb_fifo_count;
    logic        wb_overflow;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [3:0]  cnt;
        logic        strict;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clock = ~clock;

    writeback_arbiter #(.DEPTH(8), .STALL_MARGIN(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .x_wb_regdest   (x_wb_regdest),
        .x_wb_writereg  (x_wb_writereg),
        .x_wb_wbvalue   (x_wb_wbvalue),
        .y_wb_regdest   (y_wb_regdest),
        .y_wb_writereg  (y_wb_writereg),
        .y_wb_wbvalue   (y_wb_wbvalue),
        .wb_rf_regdest  (wb_rf_regdest),
        .wb_rf_writereg (wb_rf_writereg),
        .wb_rf_wbvalue  (wb_rf_wbvalue),
        .wb_is_stall    (wb_is_stall),
        .wb_fifo_count  (wb_fifo_count),
        .wb_overflow    (wb_overflow)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic cyc(input logic        r,
                       input logic        xv,
                       input logic [4:0]  xr,
                       input logic [31:0] xd,
                       input logic        yv,
                       input logic [4:0]  yr,
                       input logic [31:0] yd,
                       input logic        ewe,
                       input logic [4:0]  erd,
                       input logic [31:0] ev,
                       input logic [3:0]  ec,
                       input string       tag);
        exp_t e;
        reset         = r;
        x_wb_writereg = xv;
        x_wb_regdest  = xr;
        x_wb_wbvalue  = xd;
        y_wb_writereg = yv;
        y_wb_regdest  = yr;
        y_wb_wbvalue  = yd;
        e = '{we: ewe, rd: erd, val: ev, cnt: ec, strict: !r};
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk({tag, ".we"}, 32'(wb_rf_writereg), 32'(e.we));
        if (e.we || e.strict) begin
            chk({tag, ".rd"}, 32'(wb_rf_regdest), 32'(e.rd));
            chk({tag, ".val"}, wb_rf_wbvalue, e.val);
        end
        chk({tag, ".cnt"}, 32'(wb_fifo_count), 32'(e.cnt));
    endtask

    task automatic idle(input logic ewe,
                        input logic [4:0] erd,
                        input logic [31:0] ev,
                        input logic [3:0] ec,
                        input string tag);
        cyc(1, 0, 5'd0, 0, 0, 5'd0, 0, ewe, erd, ev, ec, tag);
    endtask

    initial begin
        // Reset with both inputs active
        cyc(0, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 0, 0, 0, "rst0");
        cyc(0, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 0, 0, 0, "rst1");
        chk("rst.stall", 32'(wb_is_stall), 0);
        chk("rst.ovf", 32'(wb_overflow), 0);

        // Y-only bypass
        cyc(1, 0, 5'd0, 0, 1, 5'd5, 32'h1234,
            1, 5'd5, 32'h1234, 0, "bypass");

        // Collision: X wins, Y buffered then popped
        cyc(1, 1, 5'd3, 32'hA, 1, 5'd4, 32'hB,
            1, 5'd3, 32'hA, 1, "coll.x");
        idle(1, 5'd4, 32'hB, 0, "coll.pop");

        // WAW squash of a buffered entry
        cyc(1, 1, 5'd1, 32'h11, 1, 5'd7, 32'h1,
            1, 5'd1, 32'h11, 1, "waw.buf");
        cyc(1, 1, 5'd7, 32'h2, 0, 5'd0, 0,
            1, 5'd7, 32'h2, 1, "waw.x");
        idle(0, 5'd7, 32'h1, 0, "waw.bubble");

        // Same-cycle WAW: Y dropped
        cyc(1, 1, 5'd9, 32'h99, 1, 5'd9, 32'h55,
            1, 5'd9, 32'h99, 0, "waw2.x");
        idle(0, 5'd0, 0, 0, "waw2.none");

        // Fill past DEPTH while X holds the port
        for (int i = 0; i < 9; i++) begin
            cyc(1, 1, 5'd1, 32'h100 + i, 1, 5'(10 + i), 32'h200 + i,
                1, 5'd1, 32'h100 + i, 4'((i < 8) ? i + 1 : 8), "fill");
            chk("fill.stall", 32'(wb_is_stall), 32'((i + 1) >= 4));
            chk("fill.ovf", 32'(wb_overflow), 32'(i == 8));
        end
        for (int i = 0; i < 8; i++) begin
            idle(1, 5'(10 + i), 32'h200 + i, 4'(7 - i), "drain");
            chk("drain.stall", 32'(wb_is_stall), 32'((7 - i) >= 4));
            chk("drain.ovf", 32'(wb_overflow), 1);
        end

        // r0 filter
        cyc(1, 1, 5'd0, 32'hFF, 1, 5'd0, 32'hEE,
            0, 0, 0, 0, "r0.empty");
        cyc(1, 1, 5'd1, 32'h31, 1, 5'd2, 32'h42,
            1, 5'd1, 32'h31, 1, "r0.p1");
        cyc(1, 1, 5'd1, 32'h32, 1, 5'd3, 32'h43,
            1, 5'd1, 32'h32, 2, "r0.p2");
        cyc(1, 1, 5'd0, 32'hFF, 1, 5'd0, 32'hEE,
            1, 5'd2, 32'h42, 1, "r0.pop");
        cyc(1, 1, 5'd1, 32'h33, 1, 5'd4, 32'h44,
            1, 5'd1, 32'h33, 2, "r0.p3");

        // Reset in the middle of a drain
        idle(1, 5'd3, 32'h43, 1, "mid.pop");
        cyc(0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, "mid.rst");
        chk("mid.ovf", 32'(wb_overflow), 0);
        chk("mid.stall", 32'(wb_is_stall), 0);
        idle(0, 5'd0, 0, 0, "mid.empty");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
